// File: rtl/candy_ifetch.sv
// candy_ifetch: instruction fetch front end.
// Issues single-outstanding SRAM word reads from a local PC, buffers the
// returned instructions in a 2-entry queue for decode, and services PC
// redirects by flushing the queue and discarding any in-flight read.
module candy_ifetch #(
   parameter int unsigned          ADDR_W   = 16,
   parameter int unsigned          DATA_W   = 32,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_fetch_en,
   input  logic              i_redirect_valid,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic              o_sram_read_enable,
   output logic [ADDR_W-1:0] o_sram_raddr,
   input  logic [DATA_W-1:0] i_sram_rdata,
   input  logic              i_sram_rdata_ready,
   output logic              o_inst_valid,
   output logic [DATA_W-1:0] o_inst,
   output logic [ADDR_W-1:0] o_inst_pc,
   input  logic              i_inst_ready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   r_req_pc;
   logic [1:0]          r_count;
   logic                r_inst_valid;
   // Slot 0 is the queue head and drives the decode outputs directly.
   logic [DATA_W-1:0]   r_data0;
   logic [DATA_W-1:0]   r_data1;
   logic [ADDR_W-1:0]   r_pc0;
   logic [ADDR_W-1:0]   r_pc1;

   logic                w_issue;
   logic                w_pop;
   logic                w_push;
   logic                w_wr0;
   logic                w_wr1;
   logic                w_shift;

   // Request strobe: only from IDLE with queue room, never under reset or redirect.
   always_comb begin
      w_issue = 1'b0;
      if (!rst && (r_state == S_IDLE) && i_fetch_en &&
          (r_count != 2'd2) && !i_redirect_valid) begin
         w_issue = 1'b1;
      end
   end

   assign o_sram_read_enable = w_issue;
   assign o_sram_raddr       = w_issue ? r_pc : '0;

   // Queue control: pop on handshake; push only for a live (non-dropped) response.
   always_comb begin
      w_pop   = r_inst_valid && i_inst_ready;
      w_push  = (r_state == S_WAIT) && i_sram_rdata_ready && !i_redirect_valid &&
                !((r_count == 2'd2) && !w_pop);
      w_wr0   = w_push && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));
      w_wr1   = w_push && (((r_count == 2'd1) && !w_pop) || ((r_count == 2'd2) && w_pop));
      w_shift = w_pop && (r_count == 2'd2);
   end

   // Fetch FSM and PC; a redirect overrides the PC and forces any in-flight read to be dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_pc     <= RESET_PC;
         r_req_pc <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  r_state  <= S_WAIT;
                  r_req_pc <= r_pc;
                  r_pc     <= r_pc + ADDR_W'(1);
               end
            end
            S_WAIT: begin
               if (i_sram_rdata_ready) begin
                  r_state <= S_IDLE;
               end else if (i_redirect_valid) begin
                  r_state <= S_DROP;
               end
            end
            S_DROP: begin
               if (i_sram_rdata_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (i_redirect_valid) begin
            r_pc <= i_redirect_pc;
         end
      end
   end

   // Two-entry instruction queue; a redirect empties it but leaves the slot contents alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count      <= 2'd0;
         r_inst_valid <= 1'b0;
         r_data0      <= '0;
         r_data1      <= '0;
         r_pc0        <= '0;
         r_pc1        <= '0;
      end else if (i_redirect_valid) begin
         r_count      <= 2'd0;
         r_inst_valid <= 1'b0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               r_count      <= r_count + 2'd1;
               r_inst_valid <= 1'b1;
            end
            2'b01: begin
               r_count      <= r_count - 2'd1;
               r_inst_valid <= (r_count != 2'd1);
            end
            default: begin
               r_count      <= r_count;
               r_inst_valid <= r_inst_valid;
            end
         endcase
         if (w_shift) begin
            r_data0 <= r_data1;
            r_pc0   <= r_pc1;
         end
         if (w_wr0) begin
            r_data0 <= i_sram_rdata;
            r_pc0   <= r_req_pc;
         end
         if (w_wr1) begin
            r_data1 <= i_sram_rdata;
            r_pc1   <= r_req_pc;
         end
      end
   end

   assign o_inst_valid = r_inst_valid;
   assign o_inst       = r_data0;
   assign o_inst_pc    = r_pc0;

endmodule

// File: tb/tb_candy_ifetch.sv
// Directed testbench for candy_ifetch: streaming, back-pressure, redirects,
// PC wrap and reset while a read is outstanding.
module tb_candy_ifetch;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fetch_en = 1'b0;
   logic          rv = 1'b0;
   logic [AW-1:0] rpc = '0;
   logic          inst_ready = 1'b0;

   logic          en, valid;
   logic [AW-1:0] raddr, inst_pc;
   logic [DW-1:0] inst, rdata;
   logic          rdy;

   logic          w_en, w_valid;
   logic [AW-1:0] w_raddr, w_inst_pc;
   logic [DW-1:0] w_inst;
   logic          wp_v = 1'b0;
   logic [DW-1:0] wp_d = '0;

   // SRAM model: mem[a] = a + 0x100, latency selected by mode (0: 1 cycle, 1: 2 cycles, 2: manual)
   int            mode = 0;
   logic          man_rdy = 1'b0;
   logic [DW-1:0] man_rdata = '0;
   logic          p1_v = 1'b0, p2_v = 1'b0;
   logic [DW-1:0] p1_d = '0, p2_d = '0;

   int checks = 0;
   int errors = 0;
   bit ok;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      p1_v <= en;
      p1_d <= DW'(raddr) + 32'h100;
      p2_v <= p1_v;
      p2_d <= p1_d;
      wp_v <= w_en;
      wp_d <= DW'(w_raddr) + 32'h100;
   end

   assign rdy   = (mode == 2) ? man_rdy   : (mode == 1) ? p2_v : p1_v;
   assign rdata = (mode == 2) ? man_rdata : (mode == 1) ? p2_d : p1_d;

   candy_ifetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .i_fetch_en(fetch_en),
      .i_redirect_valid(rv), .i_redirect_pc(rpc),
      .o_sram_read_enable(en), .o_sram_raddr(raddr),
      .i_sram_rdata(rdata), .i_sram_rdata_ready(rdy),
      .o_inst_valid(valid), .o_inst(inst), .o_inst_pc(inst_pc),
      .i_inst_ready(inst_ready)
   );

   candy_ifetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(16'hFFFF)) dut_w (
      .clk(clk), .rst(rst), .i_fetch_en(fetch_en),
      .i_redirect_valid(rv), .i_redirect_pc(rpc),
      .o_sram_read_enable(w_en), .o_sram_raddr(w_raddr),
      .i_sram_rdata(wp_d), .i_sram_rdata_ready(wp_v),
      .o_inst_valid(w_valid), .o_inst(w_inst), .o_inst_pc(w_inst_pc),
      .i_inst_ready(inst_ready)
   );

   // Advance to 1 time unit after the next rising edge; inputs are driven there, sampled 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      rst = 1'b1; fetch_en = 1'b0; rv = 1'b0; rpc = '0;
      inst_ready = 1'b0; mode = 0; man_rdy = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Bounded wait for a request to a given address; leaves time at the sample point of that cycle.
   task automatic wait_req(input logic [AW-1:0] a, input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (en && raddr == a) begin
            found = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic wait_valid(input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (valid) begin
            found = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      step();
      rst = 1'b1; fetch_en = 1'b1;
      #1;
      checks++; if (en !== 1'b0) begin errors++; $display("FAIL rst_en_held got %0h exp 0", en); end
      step();
      #1;
      checks++; if (en !== 1'b0 || raddr !== 16'h0) begin errors++; $display("FAIL rst_req got en=%0h addr=%0h exp 0/0", en, raddr); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", valid); end
      checks++; if (inst !== 32'h0 || inst_pc !== 16'h0) begin errors++; $display("FAIL rst_inst got %0h/%0h exp 0/0", inst, inst_pc); end
      step();
      rst = 1'b0; fetch_en = 1'b0;
      #1;
      checks++; if (en !== 1'b0) begin errors++; $display("FAIL fetch_off got %0h exp 0", en); end
   endtask

   task automatic test_stream();
      do_reset();
      fetch_en = 1'b1; inst_ready = 1'b1; mode = 0;
      for (int k = 0; k < 8; k++) begin
         #1;
         checks++;
         if (en !== ((k % 2) == 0)) begin errors++; $display("FAIL stream_en k=%0d got %0h", k, en); end
         if ((k % 2) == 0) begin
            checks++;
            if (raddr !== AW'(k / 2)) begin errors++; $display("FAIL stream_addr k=%0d got %0h exp %0h", k, raddr, k / 2); end
         end
         checks++;
         if (valid !== (k >= 2 && (k % 2) == 0)) begin errors++; $display("FAIL stream_valid k=%0d got %0h", k, valid); end
         if (k >= 2 && (k % 2) == 0) begin
            checks++;
            if (inst !== 32'h100 + DW'((k - 2) / 2) || inst_pc !== AW'((k - 2) / 2)) begin
               errors++; $display("FAIL stream_inst k=%0d got %0h/%0h exp %0h/%0h", k, inst, inst_pc, 32'h100 + DW'((k - 2) / 2), (k - 2) / 2);
            end
         end
         step();
      end
      fetch_en = 1'b0;
   endtask

   task automatic test_stall();
      do_reset();
      fetch_en = 1'b1; inst_ready = 1'b0; mode = 0;
      for (int k = 0; k < 6; k++) begin
         #1;
         checks++;
         if (en !== (k == 0 || k == 2)) begin errors++; $display("FAIL stall_en k=%0d got %0h", k, en); end
         if (k == 0 || k == 2) begin
            checks++;
            if (raddr !== AW'(k / 2)) begin errors++; $display("FAIL stall_addr k=%0d got %0h exp %0h", k, raddr, k / 2); end
         end
         if (k >= 2) begin
            checks++;
            if (valid !== 1'b1 || inst !== 32'h100 || inst_pc !== 16'h0) begin
               errors++; $display("FAIL stall_hold k=%0d got v=%0h %0h/%0h exp 1 100/0", k, valid, inst, inst_pc);
            end
         end
         step();
      end
      inst_ready = 1'b1;
      #1;
      checks++; if (en !== 1'b0 || inst !== 32'h100) begin errors++; $display("FAIL stall_full got en=%0h inst=%0h exp 0/100", en, inst); end
      step();
      #1;
      checks++; if (valid !== 1'b1 || inst !== 32'h101 || inst_pc !== 16'h1) begin errors++; $display("FAIL stall_pop got v=%0h %0h/%0h exp 1 101/1", valid, inst, inst_pc); end
      checks++; if (en !== 1'b1 || raddr !== 16'h2) begin errors++; $display("FAIL stall_resume got en=%0h addr=%0h exp 1/2", en, raddr); end
      fetch_en = 1'b0;
   endtask

   task automatic test_idle_redirect();
      do_reset();
      fetch_en = 1'b1; rv = 1'b1; rpc = 16'h0020;
      #1;
      checks++; if (en !== 1'b0) begin errors++; $display("FAIL idle_redir_en got %0h exp 0", en); end
      step();
      rv = 1'b0;
      #1;
      checks++; if (en !== 1'b1 || raddr !== 16'h0020) begin errors++; $display("FAIL idle_redir_req got en=%0h addr=%0h exp 1/20", en, raddr); end
      fetch_en = 1'b0;
   endtask

   task automatic test_redirect_wait();
      do_reset();
      fetch_en = 1'b1; inst_ready = 1'b1; mode = 1;
      wait_req(16'h3, 30, ok);
      checks++; if (!ok) begin errors++; $display("FAIL redir_find_req3 got timeout exp request to 3"); end
      step();
      rv = 1'b1; rpc = 16'h0040;
      #1;
      checks++; if (en !== 1'b0) begin errors++; $display("FAIL redir_wait_en got %0h exp 0", en); end
      step();
      rv = 1'b0;
      #1;
      checks++; if (en !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL redir_drop got en=%0h v=%0h exp 0/0", en, valid); end
      step();
      #1;
      checks++; if (en !== 1'b1 || raddr !== 16'h0040) begin errors++; $display("FAIL redir_req got en=%0h addr=%0h exp 1/40", en, raddr); end
      step();
      wait_valid(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL redir_valid got timeout exp inst"); end
      checks++; if (inst !== 32'h140 || inst_pc !== 16'h0040) begin errors++; $display("FAIL redir_inst got %0h/%0h exp 140/40", inst, inst_pc); end
      fetch_en = 1'b0;
   endtask

   task automatic test_coincident();
      do_reset();
      fetch_en = 1'b1; inst_ready = 1'b0; mode = 0;
      #1;
      checks++; if (en !== 1'b1 || raddr !== 16'h0) begin errors++; $display("FAIL coin_req0 got en=%0h addr=%0h exp 1/0", en, raddr); end
      step();
      step();
      #1;
      checks++; if (valid !== 1'b1 || inst !== 32'h100 || en !== 1'b1 || raddr !== 16'h1) begin
         errors++; $display("FAIL coin_setup got v=%0h inst=%0h en=%0h addr=%0h exp 1/100/1/1", valid, inst, en, raddr);
      end
      step();
      rv = 1'b1; rpc = 16'h0080; inst_ready = 1'b1;
      #1;
      checks++; if (valid !== 1'b1 || inst !== 32'h100) begin errors++; $display("FAIL coin_handshake got v=%0h inst=%0h exp 1/100", valid, inst); end
      step();
      rv = 1'b0;
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL coin_empty got %0h exp 0", valid); end
      checks++; if (en !== 1'b1 || raddr !== 16'h0080) begin errors++; $display("FAIL coin_req got en=%0h addr=%0h exp 1/80", en, raddr); end
      step();
      wait_valid(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL coin_valid got timeout exp inst"); end
      checks++; if (inst !== 32'h180 || inst_pc !== 16'h0080) begin errors++; $display("FAIL coin_inst got %0h/%0h exp 180/80", inst, inst_pc); end
      fetch_en = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      fetch_en = 1'b1; inst_ready = 1'b1; mode = 0;
      #1;
      checks++; if (w_en !== 1'b1 || w_raddr !== 16'hFFFF) begin errors++; $display("FAIL wrap_req0 got en=%0h addr=%0h exp 1/ffff", w_en, w_raddr); end
      step();
      step();
      #1;
      checks++; if (w_en !== 1'b1 || w_raddr !== 16'h0000) begin errors++; $display("FAIL wrap_req1 got en=%0h addr=%0h exp 1/0", w_en, w_raddr); end
      checks++; if (w_valid !== 1'b1 || w_inst !== 32'h100FF || w_inst_pc !== 16'hFFFF) begin
         errors++; $display("FAIL wrap_inst got v=%0h %0h/%0h exp 1 100ff/ffff", w_valid, w_inst, w_inst_pc);
      end
      fetch_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      mode = 2; man_rdy = 1'b0; fetch_en = 1'b1;
      #1;
      checks++; if (en !== 1'b1 || raddr !== 16'h0) begin errors++; $display("FAIL rmid_req got en=%0h addr=%0h exp 1/0", en, raddr); end
      step();
      rst = 1'b1; fetch_en = 1'b0;
      step();
      rst = 1'b0;
      step();
      step();
      man_rdy = 1'b1; man_rdata = 32'hDEAD;
      #1;
      checks++; if (en !== 1'b0) begin errors++; $display("FAIL rmid_noreq got %0h exp 0", en); end
      step();
      man_rdy = 1'b0;
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_nopush got %0h exp 0", valid); end
      fetch_en = 1'b1;
      #1;
      checks++; if (en !== 1'b1 || raddr !== 16'h0) begin errors++; $display("FAIL rmid_first got en=%0h addr=%0h exp 1/0", en, raddr); end
      fetch_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_idle_redirect();
      test_redirect_wait();
      test_coincident();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
